// File: rtl/rv64_multicycle_control.sv
// Multi-cycle control FSM for the RV64 datapath: sequences fetch, decode,
// execute, memory and write-back, and drives every datapath enable and select.
module rv64_multicycle_control #(
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic [2:0] state,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_is_fetch,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_sel,
   output logic [1:0] alu_a_sel,
   output logic       alu_b_sel,
   output logic       alu_word,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       instr_retired,
   output logic       illegal,
   output logic       mem_timeout
);

   localparam int unsigned CNT_W   = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
   localparam int unsigned HIT_CNT = (WAIT_MAX == 0) ? 0 : WAIT_MAX - 1;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_IMM     = 7'b0010011;
   localparam logic [6:0] OP_IMM_32  = 7'b0011011;
   localparam logic [6:0] OP_REG     = 7'b0110011;
   localparam logic [6:0] OP_REG_32  = 7'b0111011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;

   typedef enum logic [2:0] {
      S_BOOT   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_q;
   logic             timeout_now;
   logic             waiting;

   logic             legal;
   logic             is_load;
   logic             is_store;
   logic             is_branch;
   logic             is_jal;
   logic             is_jalr;
   logic [1:0]       cls_a_sel;
   logic             cls_b_sel;
   logic             cls_word;

   assign state = state_q;

   // Opcode classification and ALU operand selects per instruction class
   always_comb begin
      legal     = 1'b1;
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_branch = 1'b0;
      is_jal    = 1'b0;
      is_jalr   = 1'b0;
      cls_a_sel = 2'd0;
      cls_b_sel = 1'b0;
      cls_word  = 1'b0;
      case (opcode)
         OP_REG, OP_BRANCH: ;
         OP_REG_32:          cls_word = 1'b1;
         OP_IMM:             cls_b_sel = 1'b1;
         OP_IMM_32: begin
            cls_b_sel = 1'b1;
            cls_word  = 1'b1;
         end
         OP_LOAD: begin
            cls_b_sel = 1'b1;
            is_load   = 1'b1;
         end
         OP_STORE: begin
            cls_b_sel = 1'b1;
            is_store  = 1'b1;
         end
         OP_JALR: begin
            cls_b_sel = 1'b1;
            is_jalr   = 1'b1;
         end
         OP_LUI: begin
            cls_a_sel = 2'd2;
            cls_b_sel = 1'b1;
         end
         OP_AUIPC: begin
            cls_a_sel = 2'd1;
            cls_b_sel = 1'b1;
         end
         OP_JAL: begin
            cls_a_sel = 2'd1;
            cls_b_sel = 1'b1;
            is_jal    = 1'b1;
         end
         default:            legal = 1'b0;
      endcase
      if (opcode == OP_BRANCH) is_branch = 1'b1;
   end

   // State register; async reset abandons any instruction in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_BOOT;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_BOOT:   state_d = S_FETCH;
         S_FETCH:  if (mem_ready) state_d = S_DECODE;
         S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (is_branch)                state_d = S_FETCH;
            else if (is_load || is_store) state_d = S_MEM;
            else                          state_d = S_WB;
         end
         S_MEM:    if (mem_ready) state_d = is_load ? S_WB : S_FETCH;
         S_WB:     state_d = S_FETCH;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_BOOT;
      endcase
   end

   // Datapath controls decoded from state and opcode (Mealy on ready/branch)
   always_comb begin
      mem_req       = 1'b0;
      mem_we        = 1'b0;
      mem_is_fetch  = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_sel        = 2'd0;
      alu_a_sel     = 2'd0;
      alu_b_sel     = 1'b0;
      alu_word      = 1'b0;
      reg_write     = 1'b0;
      wb_sel        = 2'd0;
      instr_retired = 1'b0;
      illegal       = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req      = 1'b1;
            mem_is_fetch = 1'b1;
            ir_write     = mem_ready;
         end
         S_EXEC: begin
            alu_a_sel = cls_a_sel;
            alu_b_sel = cls_b_sel;
            alu_word  = cls_word;
            if (is_branch) begin
               pc_write      = 1'b1;
               pc_sel        = {1'b0, branch_taken};
               instr_retired = 1'b1;
            end
         end
         S_MEM: begin
            alu_a_sel = cls_a_sel;
            alu_b_sel = cls_b_sel;
            alu_word  = cls_word;
            mem_req   = 1'b1;
            mem_we    = is_store;
            if (is_store && mem_ready) begin
               pc_write      = 1'b1;
               instr_retired = 1'b1;
            end
         end
         S_WB: begin
            alu_a_sel     = cls_a_sel;
            alu_b_sel     = cls_b_sel;
            alu_word      = cls_word;
            reg_write     = 1'b1;
            pc_write      = 1'b1;
            instr_retired = 1'b1;
            if (is_load)               wb_sel = 2'd1;
            else if (is_jal || is_jalr) wb_sel = 2'd2;
            if (is_jal)       pc_sel = 2'd1;
            else if (is_jalr) pc_sel = 2'd2;
         end
         S_TRAP:  illegal = 1'b1;
         default: ;
      endcase
   end

   // A wait cycle is one where a request is outstanding without ready
   assign waiting     = mem_req && !mem_ready;
   assign timeout_now = (WAIT_MAX != 0) && waiting && (wait_cnt == CNT_W'(HIT_CNT));
   assign mem_timeout = timeout_q || timeout_now;

   // Saturating memory-wait counter and sticky timeout flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (mem_req && mem_ready)
            wait_cnt <= '0;
         else if (waiting && (wait_cnt != CNT_W'(WAIT_MAX)))
            wait_cnt <= wait_cnt + CNT_W'(1);
         if (timeout_now) timeout_q <= 1'b1;
      end
   end

endmodule

// File: doc/rv64_multicycle_control.md
Name: rv64_multicycle_control

Overview:
- Multi-cycle control FSM that sequences the RV64 datapath: PC, IR, register file, ALU, immediate generator and unified memory port.
- Takes the opcode from the IR plus status from the ALU and memory, and drives every datapath enable and mux select.
- One instruction is in flight at a time; the memory port is shared between instruction fetch and load/store under this FSM's control.

Parameters:
- WAIT_MAX, 255, memory-wait cycles tolerated before `mem_timeout` is flagged (0 = never flag).

Ports:
- `clk`  in  1  single clock for the block.
- `rst_n`  in  1  asynchronous active-low reset.
- `opcode`  in  7  IR[6:0]; valid from DECODE onward.
- `branch_taken`  in  1  ALU comparison result; sampled in EXEC.
- `mem_ready`  in  1  memory completes the current request.
- `state`  out  3  current FSM state, exposed for debug.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  write strobe (stores only).
- `mem_is_fetch`  out  1  request is an instruction fetch (address = PC).
- `ir_write`  out  1  load IR.
- `pc_write`  out  1  update PC.
- `pc_sel`  out  2  0 = PC+4, 1 = PC+imm, 2 = ALU result & ~1.
- `alu_a_sel`  out  2  0 = rs1, 1 = PC, 2 = zero.
- `alu_b_sel`  out  1  0 = rs2, 1 = imm.
- `alu_word`  out  1  32-bit operation with sign-extended result (OP-32, OP-IMM-32).
- `reg_write`  out  1  register file write enable.
- `wb_sel`  out  2  0 = ALU, 1 = memory data, 2 = PC+4.
- `instr_retired`  out  1  one-cycle pulse per completed instruction.
- `illegal`  out  1  sticky; an unknown opcode was decoded.
- `mem_timeout`  out  1  sticky; a memory wait exceeded WAIT_MAX.

Behaviour:
- State encoding: BOOT = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, TRAP = 6.
- Reset (async, `rst_n` = 0): state = BOOT; all outputs 0; sticky flags cleared; wait counter cleared. Reset mid-operation abandons the instruction immediately and drops `mem_req` asynchronously.
- All outputs are combinational from state and opcode. `pc_write`, `instr_retired` and `ir_write` are Mealy on `branch_taken` / `mem_ready` where noted below.
- BOOT:
  - Outputs all 0.
  - Goes to FETCH unconditionally the next cycle.
- FETCH:
  - `mem_req` = 1, `mem_is_fetch` = 1, `mem_we` = 0.
  - Holds until `mem_ready`.
  - In the `mem_ready` cycle: `ir_write` = 1, then go to DECODE.
- DECODE (1 cycle):
  - Classifies `opcode`.
  - Legal opcodes: 0000011 LOAD, 0100011 STORE, 0010011, 0011011, 0110011, 0111011, 1100011 BRANCH, 0110111 LUI, 0010111 AUIPC, 1101111 JAL, 1100111 JALR.
  - Legal -> EXEC. Any other opcode -> TRAP.
- EXEC selects by class:
  - OP / OP-32: a = rs1, b = rs2.
  - OP-IMM / OP-IMM-32 / LOAD / STORE / JALR: a = rs1, b = imm.
  - LUI: a = zero, b = imm.
  - AUIPC: a = PC, b = imm.
  - BRANCH: a = rs1, b = rs2.
  - JAL: a = PC, b = imm.
  - `alu_word` = 1 only for 0011011 and 0111011.
- EXEC next state:
  - BRANCH: `pc_write` = 1, `pc_sel` = `branch_taken` ? 1 : 0, `instr_retired` = 1, then FETCH.
  - LOAD and STORE -> MEM.
  - All others -> WB.
- MEM:
  - `mem_req` = 1, `mem_is_fetch` = 0, `mem_we` = (STORE); ALU selects held as in EXEC.
  - Holds until `mem_ready`.
  - On ready, LOAD -> WB.
  - On ready, STORE: `pc_write` = 1, `pc_sel` = 0, `instr_retired` = 1, then FETCH.
- WB (1 cycle):
  - `reg_write` = 1 and `pc_write` = 1.
  - `wb_sel`: 1 for LOAD, 2 for JAL/JALR, else 0.
  - `pc_sel`: 1 for JAL, 2 for JALR, else 0.
  - `instr_retired` = 1, then FETCH.
- TRAP:
  - `illegal` = 1; all strobes 0.
  - Stays until reset.
- Memory handshake:
  - `mem_req`, `mem_we` and `mem_is_fetch` stay stable from assertion until the `mem_ready` cycle.
  - `mem_ready` is ignored while `mem_req` = 0.
  - A zero-wait memory (`mem_ready` high in the first cycle) completes in that same cycle.
- Wait counter:
  - Counts cycles in FETCH/MEM with `mem_req` = 1 and `mem_ready` = 0; clears on `mem_ready`.
  - When it reaches WAIT_MAX (WAIT_MAX ≠ 0), `mem_timeout` is set. The FSM keeps waiting. The counter saturates.
- Latency with zero-wait memory: ALU/LUI/AUIPC/JAL/JALR = 4 cycles, BRANCH = 3, STORE = 4, LOAD = 5.
- No two of `reg_write`, `mem_we` and `ir_write` are ever high in the same cycle.

Test Plan:
- Reset release, opcode 0110011, `mem_ready` = 1 always -> states 0,1,2,3,5,1; `reg_write`, `wb_sel` = 0 and `instr_retired` high in the WB cycle only.
- Opcode 1100011 with `branch_taken` = 1, then repeated with 0 -> in EXEC, `pc_write` = 1 with `pc_sel` = 1, then `pc_sel` = 0; no `reg_write`; 3-cycle retire interval.
- LOAD (0000011) with `mem_ready` low for 3 cycles in MEM -> `mem_req` held for 4 cycles with `mem_we` = 0; then WB with `wb_sel` = 1; retire at cycle 8 after FETCH.
- STORE (0100011) -> in MEM, `mem_we` = 1 and `mem_is_fetch` = 0; `pc_write` on ready; `reg_write` never asserted.
- JALR (1100111), then opcode 1111111 -> WB has `wb_sel` = 2, `pc_sel` = 2, `alu_a_sel` = 0, `alu_b_sel` = 1; next DECODE goes to TRAP, `illegal` = 1 and stays sticky; `rst_n` pulse returns to BOOT and clears `illegal`.
- WAIT_MAX = 4, `mem_ready` held low in FETCH for 10 cycles -> `mem_timeout` rises on the 4th wait cycle and stays set after the late ready; `rst_n` asserted mid-wait drops `mem_req` in the same cycle.
